// File: rtl/snitch_acc_offload_if.sv
// Bundle of core-request, accelerator-request/response, writeback and status
// signals around the accelerator offload unit.
interface snitch_acc_offload_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 5
) ();
  logic                 core_valid_i;
  logic                 core_ready_o;
  logic [31:0]          core_op_i;
  logic [DataWidth-1:0] core_rs1_i;
  logic [DataWidth-1:0] core_rs2_i;
  logic [DataWidth-1:0] core_rs3_i;
  logic [4:0]           core_rd_i;

  logic [31:0]          acc_qaddr_o;
  logic [IdWidth-1:0]   acc_qid_o;
  logic [31:0]          acc_qdata_op_o;
  logic [DataWidth-1:0] acc_qdata_arga_o;
  logic [DataWidth-1:0] acc_qdata_argb_o;
  logic [DataWidth-1:0] acc_qdata_argc_o;
  logic                 acc_qvalid_o;
  logic                 acc_qready_i;

  logic [DataWidth-1:0] acc_pdata_i;
  logic [IdWidth-1:0]   acc_pid_i;
  logic                 acc_perror_i;
  logic                 acc_pvalid_i;
  logic                 acc_pready_o;

  logic                 wb_valid_o;
  logic                 wb_ready_i;
  logic [4:0]           wb_rd_o;
  logic [DataWidth-1:0] wb_data_o;
  logic                 wb_error_o;

  logic [31:0]          pending_rd_o;
  logic                 busy_o;
  logic                 spurious_o;

  modport master (
    input  core_valid_i, core_op_i, core_rs1_i, core_rs2_i, core_rs3_i, core_rd_i,
    input  acc_qready_i, acc_pdata_i, acc_pid_i, acc_perror_i, acc_pvalid_i, wb_ready_i,
    output core_ready_o, acc_qaddr_o, acc_qid_o, acc_qdata_op_o, acc_qdata_arga_o,
    output acc_qdata_argb_o, acc_qdata_argc_o, acc_qvalid_o, acc_pready_o,
    output wb_valid_o, wb_rd_o, wb_data_o, wb_error_o, pending_rd_o, busy_o, spurious_o
  );

  modport slave (
    output core_valid_i, core_op_i, core_rs1_i, core_rs2_i, core_rs3_i, core_rd_i,
    output acc_qready_i, acc_pdata_i, acc_pid_i, acc_perror_i, acc_pvalid_i, wb_ready_i,
    input  core_ready_o, acc_qaddr_o, acc_qid_o, acc_qdata_op_o, acc_qdata_arga_o,
    input  acc_qdata_argb_o, acc_qdata_argc_o, acc_qvalid_o, acc_pready_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, wb_error_o, pending_rd_o, busy_o, spurious_o
  );
endinterface

// File: rtl/snitch_acc_offload.sv
// Accelerator offload unit: issues core requests to an accelerator under ID slots,
// tracks destination registers and returns responses through a one-entry writeback stage.
module snitch_acc_offload #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 5,
  parameter int unsigned NumSlots  = 4,
  parameter logic [31:0] AccAddr   = 32'h0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  snitch_acc_offload_if.master bus
);

  function automatic logic [IdWidth-1:0] lowest_free(input logic [NumSlots-1:0] busy);
    lowest_free = {IdWidth{1'b0}};
    for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
      if (!busy[i]) lowest_free = IdWidth'(i);
    end
  endfunction

  logic [NumSlots-1:0]  slot_busy_r;
  logic [4:0]           slot_rd_r [NumSlots];
  logic                 q_valid_r;
  logic [IdWidth-1:0]   q_id_r;
  logic [31:0]          q_op_r;
  logic [DataWidth-1:0] q_arga_r;
  logic [DataWidth-1:0] q_argb_r;
  logic [DataWidth-1:0] q_argc_r;
  logic                 wb_valid_r;
  logic [4:0]           wb_rd_r;
  logic [DataWidth-1:0] wb_data_r;
  logic                 wb_error_r;
  logic                 spurious_r;

  logic [31:0]          pending_s;
  logic                 free_exists_s;
  logic [IdWidth-1:0]   alloc_id_s;
  logic                 core_ready_s;
  logic                 issue_s;
  logic                 resp_ready_s;
  logic                 resp_fire_s;
  logic                 resp_known_s;
  logic [4:0]           resp_rd_s;
  logic [NumSlots-1:0]  alloc_s;
  logic [NumSlots-1:0]  release_s;

  // Scoreboard, slot lookup and handshake qualifiers, all from registered state.
  always_comb begin
    pending_s     = 32'h0;
    resp_known_s  = 1'b0;
    resp_rd_s     = 5'd0;
    free_exists_s = ~&slot_busy_r;
    alloc_id_s    = lowest_free(slot_busy_r);
    core_ready_s  = (~q_valid_r | bus.acc_qready_i) & free_exists_s & ~pending_s[bus.core_rd_i];
    for (int i = 0; i < int'(NumSlots); i++) begin
      pending_s[slot_rd_r[i]] = pending_s[slot_rd_r[i]] |
                                (slot_busy_r[i] & (slot_rd_r[i] != 5'd0));
      resp_known_s = resp_known_s | (slot_busy_r[i] & (bus.acc_pid_i == IdWidth'(i)));
      resp_rd_s    = resp_rd_s | (slot_rd_r[i] & {5{bus.acc_pid_i == IdWidth'(i)}});
    end
    core_ready_s = (~q_valid_r | bus.acc_qready_i) & free_exists_s & ~pending_s[bus.core_rd_i];
    issue_s      = bus.core_valid_i & core_ready_s;
    resp_ready_s = ~wb_valid_r | bus.wb_ready_i;
    resp_fire_s  = bus.acc_pvalid_i & resp_ready_s;
    for (int i = 0; i < int'(NumSlots); i++) begin
      alloc_s[i]   = issue_s & (alloc_id_s == IdWidth'(i));
      release_s[i] = resp_fire_s & resp_known_s & (bus.acc_pid_i == IdWidth'(i));
    end
  end

  // Slot table: allocation only hits free slots and release only busy ones, so they never collide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_busy_r <= {NumSlots{1'b0}};
      for (int i = 0; i < int'(NumSlots); i++) slot_rd_r[i] <= 5'd0;
    end else begin
      for (int i = 0; i < int'(NumSlots); i++) begin
        if (alloc_s[i]) begin
          slot_busy_r[i] <= 1'b1;
          slot_rd_r[i]   <= bus.core_rd_i;
        end else if (release_s[i]) begin
          slot_busy_r[i] <= 1'b0;
        end
      end
    end
  end

  // Request register: holds until the accelerator accepts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_valid_r <= 1'b0;
      q_id_r    <= {IdWidth{1'b0}};
      q_op_r    <= 32'h0;
      q_arga_r  <= {DataWidth{1'b0}};
      q_argb_r  <= {DataWidth{1'b0}};
      q_argc_r  <= {DataWidth{1'b0}};
    end else if (issue_s) begin
      q_valid_r <= 1'b1;
      q_id_r    <= alloc_id_s;
      q_op_r    <= bus.core_op_i;
      q_arga_r  <= bus.core_rs1_i;
      q_argb_r  <= bus.core_rs2_i;
      q_argc_r  <= bus.core_rs3_i;
    end else if (bus.acc_qready_i) begin
      q_valid_r <= 1'b0;
    end
  end

  // Writeback register and spurious-response flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= {DataWidth{1'b0}};
      wb_error_r <= 1'b0;
      spurious_r <= 1'b0;
    end else begin
      spurious_r <= resp_fire_s & ~resp_known_s;
      if (resp_fire_s && resp_known_s) begin
        wb_valid_r <= 1'b1;
        wb_rd_r    <= resp_rd_s;
        wb_data_r  <= bus.acc_pdata_i;
        wb_error_r <= bus.acc_perror_i;
      end else if (bus.wb_ready_i) begin
        wb_valid_r <= 1'b0;
      end
    end
  end

  assign bus.core_ready_o     = core_ready_s;
  assign bus.acc_qaddr_o      = AccAddr;
  assign bus.acc_qid_o        = q_id_r;
  assign bus.acc_qdata_op_o   = q_op_r;
  assign bus.acc_qdata_arga_o = q_arga_r;
  assign bus.acc_qdata_argb_o = q_argb_r;
  assign bus.acc_qdata_argc_o = q_argc_r;
  assign bus.acc_qvalid_o     = q_valid_r;
  assign bus.acc_pready_o     = resp_ready_s;
  assign bus.wb_valid_o       = wb_valid_r;
  assign bus.wb_rd_o          = wb_rd_r;
  assign bus.wb_data_o        = wb_data_r;
  assign bus.wb_error_o       = wb_error_r;
  assign bus.pending_rd_o     = pending_s;
  assign bus.busy_o           = |slot_busy_r;
  assign bus.spurious_o       = spurious_r;

endmodule

// File: tb/tb_snitch_acc_offload.sv
// Directed, table-driven bench for snitch_acc_offload with hand-written corner sequences.
module tb_snitch_acc_offload;
  localparam logic [31:0] ADDR = 32'hCAFE_0000;
  localparam logic [31:0] MUL  = 32'h02C3_82B3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  snitch_acc_offload_if #(.DataWidth(32), .IdWidth(5)) bus ();

  snitch_acc_offload #(.DataWidth(32), .IdWidth(5), .NumSlots(4), .AccAddr(ADDR)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic cv; logic [4:0] rd; logic [31:0] rs1; logic qr;
    logic pv; logic [4:0] pid; logic [31:0] pdata; logic wr;
    logic crdy; logic prdy;
    logic qv; logic [4:0] qid; logic [31:0] arga;
    logic wbv; logic [4:0] wbrd; logic [31:0] wbdata; logic [31:0] pend; logic bsy;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic cv, input logic [4:0] rd, input logic [31:0] rs1,
                       input logic qr, input logic pv, input logic [4:0] pid,
                       input logic [31:0] pdata, input logic perr, input logic wr);
    bus.core_valid_i = cv;
    bus.core_op_i    = MUL;
    bus.core_rd_i    = rd;
    bus.core_rs1_i   = rs1;
    bus.core_rs2_i   = 32'd6;
    bus.core_rs3_i   = 32'd0;
    bus.acc_qready_i = qr;
    bus.acc_pvalid_i = pv;
    bus.acc_pid_i    = pid;
    bus.acc_pdata_i  = pdata;
    bus.acc_perror_i = perr;
    bus.wb_ready_i   = wr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    //          cv   rd     rs1      qr   pv   pid    pdata    wr   crdy prdy qv   qid    arga     wbv  wbrd   wbdata   pend      bsy
    vt[0]  = '{1'b1,5'd5,32'h07,1'b1,1'b0,5'd0,32'h00,1'b1,1'b1,1'b1,1'b1,5'd0,32'h07,1'b0,5'd0,32'h00,32'h20,1'b1};
    vt[1]  = '{1'b0,5'd0,32'h00,1'b1,1'b1,5'd0,32'd42,1'b1,1'b1,1'b1,1'b0,5'd0,32'h07,1'b1,5'd5,32'd42,32'h00,1'b0};
    vt[2]  = '{1'b0,5'd0,32'h00,1'b1,1'b0,5'd0,32'h00,1'b1,1'b1,1'b1,1'b0,5'd0,32'h07,1'b0,5'd5,32'd42,32'h00,1'b0};
    vt[3]  = '{1'b1,5'd1,32'h01,1'b1,1'b0,5'd0,32'h00,1'b1,1'b1,1'b1,1'b1,5'd0,32'h01,1'b0,5'd5,32'd42,32'h02,1'b1};
    vt[4]  = '{1'b1,5'd2,32'h02,1'b1,1'b0,5'd0,32'h00,1'b1,1'b1,1'b1,1'b1,5'd1,32'h02,1'b0,5'd5,32'd42,32'h06,1'b1};
    vt[5]  = '{1'b1,5'd3,32'h03,1'b1,1'b0,5'd0,32'h00,1'b1,1'b1,1'b1,1'b1,5'd2,32'h03,1'b0,5'd5,32'd42,32'h0E,1'b1};
    vt[6]  = '{1'b1,5'd4,32'h04,1'b1,1'b0,5'd0,32'h00,1'b1,1'b1,1'b1,1'b1,5'd3,32'h04,1'b0,5'd5,32'd42,32'h1E,1'b1};
    vt[7]  = '{1'b1,5'd6,32'h09,1'b1,1'b0,5'd0,32'h00,1'b1,1'b0,1'b1,1'b0,5'd3,32'h04,1'b0,5'd5,32'd42,32'h1E,1'b1};
    vt[8]  = '{1'b1,5'd6,32'h09,1'b1,1'b1,5'd2,32'h33,1'b1,1'b0,1'b1,1'b0,5'd3,32'h04,1'b1,5'd3,32'h33,32'h16,1'b1};
    vt[9]  = '{1'b1,5'd6,32'h09,1'b1,1'b0,5'd0,32'h00,1'b1,1'b1,1'b1,1'b1,5'd2,32'h09,1'b0,5'd3,32'h33,32'h56,1'b1};
    vt[10] = '{1'b0,5'd0,32'h00,1'b1,1'b1,5'd3,32'h44,1'b1,1'b0,1'b1,1'b0,5'd2,32'h09,1'b1,5'd4,32'h44,32'h46,1'b1};
    vt[11] = '{1'b1,5'd5,32'h55,1'b1,1'b1,5'd0,32'h11,1'b1,1'b1,1'b1,1'b1,5'd3,32'h55,1'b1,5'd1,32'h11,32'h64,1'b1};
    vt[12] = '{1'b1,5'd5,32'h66,1'b1,1'b1,5'd3,32'h77,1'b1,1'b0,1'b1,1'b0,5'd3,32'h55,1'b1,5'd5,32'h77,32'h44,1'b1};
    vt[13] = '{1'b1,5'd5,32'h66,1'b1,1'b0,5'd0,32'h00,1'b1,1'b1,1'b1,1'b1,5'd0,32'h66,1'b0,5'd5,32'h77,32'h64,1'b1};
    vt[14] = '{1'b0,5'd0,32'h00,1'b1,1'b1,5'd0,32'h01,1'b1,1'b1,1'b1,1'b0,5'd0,32'h66,1'b1,5'd5,32'h01,32'h44,1'b1};
    vt[15] = '{1'b0,5'd0,32'h00,1'b1,1'b1,5'd1,32'h02,1'b1,1'b1,1'b1,1'b0,5'd0,32'h66,1'b1,5'd2,32'h02,32'h40,1'b1};
    vt[16] = '{1'b0,5'd0,32'h00,1'b1,1'b1,5'd2,32'h03,1'b1,1'b1,1'b1,1'b0,5'd0,32'h66,1'b1,5'd6,32'h03,32'h00,1'b0};
    vt[17] = '{1'b0,5'd0,32'h00,1'b1,1'b0,5'd0,32'h00,1'b1,1'b1,1'b1,1'b0,5'd0,32'h66,1'b0,5'd6,32'h03,32'h00,1'b0};

    idle();
    #2;
    chk("rst_qaddr", bus.acc_qaddr_o, ADDR);
    chk("rst_qvalid", {31'd0, bus.acc_qvalid_o}, 32'd0);
    chk("rst_wbvalid", {31'd0, bus.wb_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_pending", bus.pending_rd_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      drive(vt[k].cv, vt[k].rd, vt[k].rs1, vt[k].qr, vt[k].pv, vt[k].pid, vt[k].pdata, 1'b0, vt[k].wr);
      #1;
      chk($sformatf("v%0d_core_ready", k), {31'd0, bus.core_ready_o}, {31'd0, vt[k].crdy});
      chk($sformatf("v%0d_acc_pready", k), {31'd0, bus.acc_pready_o}, {31'd0, vt[k].prdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_qvalid", k), {31'd0, bus.acc_qvalid_o}, {31'd0, vt[k].qv});
      chk($sformatf("v%0d_qid", k), {27'd0, bus.acc_qid_o}, {27'd0, vt[k].qid});
      chk($sformatf("v%0d_arga", k), bus.acc_qdata_arga_o, vt[k].arga);
      chk($sformatf("v%0d_wbvalid", k), {31'd0, bus.wb_valid_o}, {31'd0, vt[k].wbv});
      chk($sformatf("v%0d_wbrd", k), {27'd0, bus.wb_rd_o}, {27'd0, vt[k].wbrd});
      chk($sformatf("v%0d_wbdata", k), bus.wb_data_o, vt[k].wbdata);
      chk($sformatf("v%0d_pending", k), bus.pending_rd_o, vt[k].pend);
      chk($sformatf("v%0d_busy", k), {31'd0, bus.busy_o}, {31'd0, vt[k].bsy});
      chk($sformatf("v%0d_spurious", k), {31'd0, bus.spurious_o}, 32'd0);
    end

    // Accelerator back-pressure: request held stable, next request waits.
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h0A, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    #1 chk("bp_first_ready", {31'd0, bus.core_ready_o}, 32'd1);
    @(posedge clk); #1;
    chk("bp_first_qid", {27'd0, bus.acc_qid_o}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd8, 32'h0B, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      #1 chk("bp_stall_ready", {31'd0, bus.core_ready_o}, 32'd0);
      @(posedge clk); #1;
      chk("bp_hold_qvalid", {31'd0, bus.acc_qvalid_o}, 32'd1);
      chk("bp_hold_qid", {27'd0, bus.acc_qid_o}, 32'd0);
      chk("bp_hold_arga", bus.acc_qdata_arga_o, 32'h0A);
      chk("bp_hold_op", bus.acc_qdata_op_o, MUL);
      chk("bp_hold_argb", bus.acc_qdata_argb_o, 32'd6);
    end
    @(negedge clk);
    drive(1'b1, 5'd8, 32'h0B, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    #1 chk("bp_release_ready", {31'd0, bus.core_ready_o}, 32'd1);
    @(posedge clk); #1;
    chk("bp_next_qvalid", {31'd0, bus.acc_qvalid_o}, 32'd1);
    chk("bp_next_qid", {27'd0, bus.acc_qid_o}, 32'd1);
    chk("bp_next_arga", bus.acc_qdata_arga_o, 32'h0B);
    @(negedge clk); idle();
    @(posedge clk); #1 chk("bp_drain_qvalid", {31'd0, bus.acc_qvalid_o}, 32'd0);
    @(negedge clk); drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'h100, 1'b0, 1'b1);
    @(posedge clk); #1 chk("bp_wb0_rd", {27'd0, bus.wb_rd_o}, 32'd7);
    @(negedge clk); drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd1, 32'h200, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("bp_wb1_rd", {27'd0, bus.wb_rd_o}, 32'd8);
    chk("bp_wb1_data", bus.wb_data_o, 32'h200);
    @(negedge clk); idle();
    @(posedge clk); #1 chk("bp_idle_busy", {31'd0, bus.busy_o}, 32'd0);

    // Unknown-ID response, then writeback back-pressure.
    @(negedge clk); drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd3, 32'h5A, 1'b0, 1'b1);
    #1 chk("sp_pready", {31'd0, bus.acc_pready_o}, 32'd1);
    @(posedge clk); #1;
    chk("sp_pulse", {31'd0, bus.spurious_o}, 32'd1);
    chk("sp_wbvalid", {31'd0, bus.wb_valid_o}, 32'd0);
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("sp_pulse_end", {31'd0, bus.spurious_o}, 32'd0);
    chk("sp_busy", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk); drive(1'b1, 5'd9, 32'd1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(1'b1, 5'd10, 32'd2, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk); idle();
    @(posedge clk);
    @(negedge clk); drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'h99, 1'b1, 1'b0);
    #1 chk("wbp_first_pready", {31'd0, bus.acc_pready_o}, 32'd1);
    @(posedge clk); #1;
    chk("wbp_first_valid", {31'd0, bus.wb_valid_o}, 32'd1);
    chk("wbp_first_rd", {27'd0, bus.wb_rd_o}, 32'd9);
    chk("wbp_first_err", {31'd0, bus.wb_error_o}, 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd1, 32'hAA, 1'b0, 1'b0);
      #1 chk("wbp_stall_pready", {31'd0, bus.acc_pready_o}, 32'd0);
      @(posedge clk); #1;
      chk("wbp_hold_rd", {27'd0, bus.wb_rd_o}, 32'd9);
      chk("wbp_hold_data", bus.wb_data_o, 32'h99);
      chk("wbp_hold_pending", bus.pending_rd_o, 32'h400);
    end
    @(negedge clk); drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd1, 32'hAA, 1'b0, 1'b1);
    #1 chk("wbp_drain_pready", {31'd0, bus.acc_pready_o}, 32'd1);
    @(posedge clk); #1;
    chk("wbp_second_valid", {31'd0, bus.wb_valid_o}, 32'd1);
    chk("wbp_second_rd", {27'd0, bus.wb_rd_o}, 32'd10);
    chk("wbp_second_data", bus.wb_data_o, 32'hAA);
    chk("wbp_second_err", {31'd0, bus.wb_error_o}, 32'd0);
    chk("wbp_second_busy", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk); idle();
    @(posedge clk); #1 chk("wbp_final_valid", {31'd0, bus.wb_valid_o}, 32'd0);

    // Reset with outstanding requests, then a late response.
    @(negedge clk); drive(1'b1, 5'd11, 32'd1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(1'b1, 5'd12, 32'd2, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("mr_pending_before", bus.pending_rd_o, 32'h1800);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("mr_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("mr_pending", bus.pending_rd_o, 32'd0);
    chk("mr_qvalid", {31'd0, bus.acc_qvalid_o}, 32'd0);
    chk("mr_qaddr", bus.acc_qaddr_o, ADDR);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'h12, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("mr_late_spurious", {31'd0, bus.spurious_o}, 32'd1);
    chk("mr_late_wbvalid", {31'd0, bus.wb_valid_o}, 32'd0);
    chk("mr_late_busy", {31'd0, bus.busy_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
